// File: rtl/checksum_decode.sv
// ---------------------------------------------------------------------------
// checksum_decode
//
// Recovers the data word from a coded word that was produced by multiplying
// the data by a sign-magnitude coefficient.  The coded word is made
// non-negative (two's complement undone when the coefficient is negative),
// then divided by the coefficient magnitude with an iterative restoring
// divider.  A non-zero remainder, a quotient that does not fit the output
// width, or a zero magnitude all flag a decode failure.
//
// Build option:
//   CHECKSUM_DECODE_RADIX4_EN  - when defined, the divider retires two
//                                quotient bits per cycle (accept to result
//                                19 cycles instead of 36).  Results are
//                                identical in both builds.
//
// Ports:
//   clk           - single clock, all logic on its rising edge
//   reset         - asynchronous active-low reset
//   in_data_vld   - coded word and coefficient are valid this cycle
//   in_data       - coded word (two's complement when coefficient negative)
//   polynomial    - sign-magnitude coefficient, MSB is the sign
//   in_rdy        - block is idle and will accept in_data_vld
//   out_data      - recovered data word, held between results
//   out_err       - decode failure flag, valid with out_data_vld
//   out_data_vld  - single-cycle result strobe
// ---------------------------------------------------------------------------
module checksum_decode #(
    parameter int IN_DATA_WIDTH  = 34,
    parameter int POLY_WIDTH     = 17,
    parameter int OUT_DATA_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_data_vld,
    input  logic [IN_DATA_WIDTH-1:0]  in_data,
    input  logic [POLY_WIDTH-1:0]     polynomial,
    output logic                      in_rdy,
    output logic [OUT_DATA_WIDTH-1:0] out_data,
    output logic                      out_err,
    output logic                      out_data_vld
);

    localparam int MAG_WIDTH = POLY_WIDTH - 1;

`ifdef CHECKSUM_DECODE_RADIX4_EN
    localparam int BITS_PER_ITER = 2;
`else
    localparam int BITS_PER_ITER = 1;
`endif

    localparam logic [5:0] LAST_ITER = 6'(IN_DATA_WIDTH / BITS_PER_ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    state_t                   state;
    logic [5:0]               iter_cnt;
    // Holds the dividend at first; quotient bits shift in at the bottom as
    // dividend bits shift out of the top, so it ends up as the quotient.
    logic [IN_DATA_WIDTH-1:0] quo_q;
    logic [MAG_WIDTH-1:0]     rem_q;
    logic [MAG_WIDTH-1:0]     divisor_q;
    logic                     sign_q;

    logic [MAG_WIDTH:0]       trial_a;
    logic                     bit_a;
    logic [MAG_WIDTH-1:0]     rem_a;
    logic [IN_DATA_WIDTH-1:0] quo_a;
`ifdef CHECKSUM_DECODE_RADIX4_EN
    logic [MAG_WIDTH:0]       trial_b;
    logic                     bit_b;
    logic [MAG_WIDTH-1:0]     rem_b;
    logic [IN_DATA_WIDTH-1:0] quo_b;
`endif
    logic [MAG_WIDTH-1:0]     rem_next;
    logic [IN_DATA_WIDTH-1:0] quo_next;

    assign in_rdy = (state == IDLE);

    // One restoring-division step: bring down the next dividend bit, and
    // subtract the divisor if it fits.  The radix-4 build chains a second
    // identical step behind the first in the same cycle.
    always_comb begin
        trial_a = {rem_q, quo_q[IN_DATA_WIDTH-1]};
        bit_a   = (trial_a >= {1'b0, divisor_q});
        rem_a   = bit_a ? MAG_WIDTH'(trial_a - {1'b0, divisor_q})
                        : trial_a[MAG_WIDTH-1:0];
        quo_a   = {quo_q[IN_DATA_WIDTH-2:0], bit_a};
`ifdef CHECKSUM_DECODE_RADIX4_EN
        trial_b  = {rem_a, quo_a[IN_DATA_WIDTH-1]};
        bit_b    = (trial_b >= {1'b0, divisor_q});
        rem_b    = bit_b ? MAG_WIDTH'(trial_b - {1'b0, divisor_q})
                         : trial_b[MAG_WIDTH-1:0];
        quo_b    = {quo_a[IN_DATA_WIDTH-2:0], bit_b};
        rem_next = rem_b;
        quo_next = quo_b;
`else
        rem_next = rem_a;
        quo_next = quo_a;
`endif
    end

    // Control FSM and datapath.  The result strobe is raised on the edge
    // that leaves DONE, so it is visible in the following IDLE cycle while
    // in_rdy is already high and a new word can be taken on the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            iter_cnt     <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            divisor_q    <= '0;
            sign_q       <= 1'b0;
            out_data     <= '0;
            out_err      <= 1'b0;
            out_data_vld <= 1'b0;
        end else begin
            out_data_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_data_vld) begin
                        quo_q     <= in_data;
                        divisor_q <= polynomial[MAG_WIDTH-1:0];
                        sign_q    <= polynomial[POLY_WIDTH-1];
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Negating modulo 2^IN_DATA_WIDTH undoes the two's
                    // complement applied when the coefficient was negative.
                    if (sign_q) begin
                        quo_q <= -quo_q;
                    end
                    rem_q    <= '0;
                    iter_cnt <= '0;
                    state    <= (divisor_q != '0) ? DIV : DONE;
                end
                DIV: begin
                    quo_q    <= quo_next;
                    rem_q    <= rem_next;
                    iter_cnt <= iter_cnt + 6'd1;
                    if (iter_cnt == LAST_ITER) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    out_data_vld <= 1'b1;
                    if (divisor_q == '0) begin
                        out_data <= '0;
                        out_err  <= 1'b1;
                    end else begin
                        out_data <= quo_q[OUT_DATA_WIDTH-1:0];
                        out_err  <= (rem_q != '0) ||
                                    (|quo_q[IN_DATA_WIDTH-1:OUT_DATA_WIDTH]);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/checksum_decode.md
CHECKSUM_DECODE -- requirements
Module: checksum_decode

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 34, width of the coded word to decode.
REQ-002 SHALL have parameter POLY_WIDTH, default 17, coefficient width: bit 16 is the sign, bits [15:0] the magnitude.
REQ-003 SHALL have parameter OUT_DATA_WIDTH, default 17, width of the recovered data word.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_data_vld, input, 1, coded word and coefficient valid this cycle.
REQ-007 SHALL have port in_data, input, 34, coded word (product, two's complement when the coefficient is negative).
REQ-008 SHALL have port polynomial, input, 17, sign-magnitude coefficient used to encode.
REQ-009 SHALL have port in_rdy, output, 1, block idle and able to accept.
REQ-010 SHALL have port out_data, output, 17, recovered data word.
REQ-011 SHALL have port out_err, output, 1, decode failure flag, valid with out_data_vld.
REQ-012 SHALL have port out_data_vld, output, 1, single-cycle result strobe.

Function
REQ-013 SHALL accept a request on a rising edge where in_data_vld=1 and in_rdy=1, and register in_data and polynomial.
REQ-014 SHALL ignore and drop in_data_vld while in_rdy=0, with no error and no queuing.
REQ-015 SHALL implement FSM states IDLE, LOAD, DIV, DONE: IDLE->LOAD on accept; LOAD->DIV when magnitude!=0; LOAD->DONE when magnitude=0; DIV->DONE after the last iteration; DONE->IDLE unconditionally.
REQ-016 SHALL drive in_rdy=1 only in IDLE.
REQ-017 SHALL, in LOAD, replace the dividend with (2^34 - in_data) mod 2^34 when polynomial[16]=1, and leave it unchanged otherwise.
REQ-018 SHALL, in DIV, perform unsigned restoring division of the 34-bit dividend by polynomial[15:0], one quotient bit per cycle MSB-first, 34 cycles, with a 6-bit iteration counter.
REQ-019 SHALL, in DONE, drive out_data = quotient[16:0] and out_data_vld=1 for exactly one cycle.
REQ-020 SHALL set out_err=1 when remainder!=0, or quotient > 131071, or magnitude=0; otherwise out_err=0.
REQ-021 SHALL, for magnitude=0, set out_data=0 and out_err=1.
REQ-022 SHALL assert out_data_vld 36 cycles after the accepting edge for a nonzero divisor, and 2 cycles after it for a zero divisor.
REQ-023 SHALL hold out_data and out_err at their last values when out_data_vld=0.
REQ-024 SHALL allow a new accept on the edge immediately following DONE, giving a throughput of one word per 37 cycles.

Reset
REQ-025 SHALL, on reset=0, immediately force: state=IDLE, counter=0, in_rdy=1, out_data=0, out_err=0, out_data_vld=0.
REQ-026 SHALL, on reset mid-operation, abandon the operation, produce no out_data_vld, and accept again on the first edge after release.

Configuration
REQ-027 SHALL support the macro CHECKSUM_DECODE_RADIX4_EN.
REQ-028 SHALL, when CHECKSUM_DECODE_RADIX4_EN is defined, retire 2 quotient bits per cycle in DIV (17 cycles) and assert out_data_vld 19 cycles after accept.
REQ-029 SHALL, when CHECKSUM_DECODE_RADIX4_EN is undefined, use radix-2 with 36-cycle latency.
REQ-030 SHALL produce results and out_err identical in both builds; the zero-divisor latency stays 2 cycles in both.

Verification
REQ-031 SHALL cover: in_data=8590131199, polynomial=131071 -> out_data=131071, out_err=0, out_data_vld at accept+36 (accept+19 with RADIX4).
REQ-032 SHALL cover: in_data=100, polynomial=7 -> out_data=14, out_err=1 (remainder 2).
REQ-033 SHALL cover: in_data=8589803520, polynomial=65535 -> quotient 131072 overflows, out_data=0, out_err=1.
REQ-034 SHALL cover: polynomial=65536 (magnitude 0), any in_data -> out_data=0, out_err=1, out_data_vld at accept+2.
REQ-035 SHALL cover: second in_data_vld pulse 5 cycles after accept -> ignored, exactly one out_data_vld, in_rdy=0 until DONE completes.
REQ-036 SHALL cover: reset=0 on cycle 10 of DIV -> in_rdy=1, no out_data_vld; then in_data=21, polynomial=3 -> out_data=7, out_err=0.
